matmul_register_bank: RTL and testbench
=======================================

# matmul_register_bank

Register and operand storage that sits directly downstream of the APB slave in the matmul accelerator. It consumes the slave's `address_o`, `strobe_o` and `bus_mem_o`, and returns read data on `bus_mem_i`. It holds operand matrices A and B, the control/start register, the result scratchpad (SP) and the FLAGS register. It also sequences the start/done handshake with the matmul engine.

## Interface
Parameters:
- DATA_WIDTH, 32: element width; one strobe lane per element.
- BUS_WIDTH, 64: row width.
- ADDR_WIDTH, 32: address width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (derived): matrix rows and strobe lanes.
- IDX_W, max(1, clog2(MAX_DIM)) (derived): row index width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- address_i  in  ADDR_WIDTH  address from the APB slave. Bits [4:0] select the region; bits [5+:IDX_W] select the row.
- strobe_i  in  MAX_DIM  per-lane write enable; non-zero means write this cycle.
- wdata_i  in  BUS_WIDTH  write data (the slave's `bus_mem_o`).
- rdata_o  out  BUS_WIDTH  combinational read data (the slave's `bus_mem_i`).
- start_bit_o  out  1  engine running; also blocks APB access in the slave.
- done_i  in  1  one-cycle pulse from the engine: computation finished.
- flags_i  in  BUS_WIDTH  engine flags, sampled on done_i.
- eng_row_i  in  IDX_W  engine operand row select.
- eng_a_o, eng_b_o  out  BUS_WIDTH  registered operand rows.
- sp_we_i  in  1  engine scratchpad write enable.
- sp_row_i  in  IDX_W  scratchpad row.
- sp_data_i  in  BUS_WIDTH  scratchpad write data.

## Operation
- Region map on address_i[4:0]:
  - 0x00 CONTROL (R/W)
  - 0x04 OPERAND_A (R/W)
  - 0x08 OPERAND_B (R/W)
  - 0x0C FLAGS (RO)
  - 0x10 SP (RO)
  - Other values read 0; writes to them are ignored.
- Writes: lane b of the selected row takes wdata_i[(b+1)*DATA_WIDTH-1 -: DATA_WIDTH] when strobe_i[b]=1. Other lanes are unchanged.
- Writes to FLAGS and SP are ignored.
- CONTROL layout: bit0 = START, bit1 = DONE (sticky, read-only). Only lane 0 is writable.
- State machine, states IDLE and RUN:
  - IDLE→RUN when CONTROL is written with bit0=1.
  - RUN→IDLE on done_i. On that transition: START clears, DONE sets, FLAGS ← flags_i.
- start_bit_o = (state==RUN).
- Writing CONTROL with bit0=1 also clears DONE.
- During RUN:
  - APB writes to CONTROL, OPERAND_A and OPERAND_B are ignored.
  - Reads return current contents.
- sp_we_i writes SP[sp_row_i] ← sp_data_i, in RUN only; ignored in IDLE.
- Engine port: eng_a_o ← A[eng_row_i] and eng_b_o ← B[eng_row_i] every cycle (registered).
- Simultaneous events:
  - done_i with a CONTROL write in the same cycle: done_i wins and the write is dropped.
  - done_i with sp_we_i in the same cycle: the SP write completes.
  - Row index ≥ MAX_DIM: reads return 0, writes are ignored.

## Timing
- Reset (asynchronous): state IDLE, start_bit_o=0, eng_a_o=eng_b_o=0, all storage, CONTROL and FLAGS = 0.
- rdata_o: zero-latency combinational from address_i and storage. The slave captures it in its access phase.
- Write visibility: a write at edge N is visible on rdata_o after edge N.
- start_bit_o rises the cycle after the CONTROL write edge.
- start_bit_o falls the cycle after the done_i edge.
- FLAGS and DONE are readable from the cycle after done_i.
- eng_a_o and eng_b_o have 1-cycle latency from eng_row_i.
- Reset asserted during RUN: start_bit_o drops immediately; the engine must be reset by the same signal.

## Structure
- Shared package, common with the APB slave:
  - region codes CONTROL, OPERAND_A, OPERAND_B, FLAGS, SP
  - CONTROL bit positions
  - state encoding IDLE=1'b0, RUN=1'b1
- One sub-module, `matmul_row_mem`: MAX_DIM × BUS_WIDTH storage with a lane-strobed write port, a combinational read port and a registered read port. It is instantiated for A and for B.
- SP and the control FSM are implemented in the top level.

## Test plan
- Write OPERAND_A row 1 with strobe=2'b01 and data 0xAAAA_BBBB_1111_2222 over existing 0 → read returns 0x0000_0000_1111_2222.
- Write CONTROL=1 → start_bit_o=1 from the next cycle. Then write OPERAND_B row 0 = 0x5 → it is ignored, and row 0 still reads 0.
- In RUN, pulse done_i with flags_i=0x3 → start_bit_o=0 and FLAGS reads 0x3 from the next cycle. CONTROL reads 0x2; a subsequent START write reads 0x1.
- In RUN, sp_we_i with row 1 and data 0xDEAD_BEEF_0000_0001 → SP row 1 reads that value. In IDLE the same sp_we_i leaves SP unchanged.
- done_i in the same cycle as a CONTROL write of 1 → state IDLE and DONE=1. Write FLAGS=0xFF → it is ignored.
- Assert rst_i mid-RUN → start_bit_o=0 asynchronously, and all registers read 0 after release.

Source files
------------

// File: rtl/matmul_register_bank_pkg.sv
// rtl/matmul_register_bank_pkg.sv - shared region codes, CONTROL bits and FSM encoding
// Purpose: definitions shared by the matmul APB slave and the register bank.
// Ports: none (package).
package matmul_register_bank_pkg;

  // Region codes decoded from address bits [4:0]
  localparam logic [4:0] REG_CONTROL   = 5'h00;
  localparam logic [4:0] REG_OPERAND_A = 5'h04;
  localparam logic [4:0] REG_OPERAND_B = 5'h08;
  localparam logic [4:0] REG_FLAGS     = 5'h0C;
  localparam logic [4:0] REG_SP        = 5'h10;

  // CONTROL register bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/matmul_row_mem.sv
// rtl/matmul_row_mem.sv - MAX_DIM x BUS_WIDTH operand storage with lane-strobed writes
// Purpose: holds one operand matrix; one row per entry, one strobe lane per element.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   we_i, wrow_i      write enable and row
//   strobe_i, wdata_i per-lane write enables and write data
//   rrow_i, rdata_o   combinational read port (bus side)
//   eng_row_i, eng_data_o registered read port (engine side, 1-cycle latency)
module matmul_row_mem
  import matmul_register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     wrow_i,
  input  logic [MAX_DIM-1:0]   strobe_i,
  input  logic [BUS_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]     rrow_i,
  output logic [BUS_WIDTH-1:0] rdata_o,
  input  logic [IDX_W-1:0]     eng_row_i,
  output logic [BUS_WIDTH-1:0] eng_data_o
);

  logic [BUS_WIDTH-1:0] mem_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] mem_d [MAX_DIM];
  logic [BUS_WIDTH-1:0] eng_data_q, eng_data_d;

  always_comb begin
    mem_d = mem_q;
    // Rows beyond MAX_DIM have no storage: writes vanish, reads return 0.
    if (we_i && (32'(wrow_i) < MAX_DIM)) begin
      for (int b = 0; b < MAX_DIM; b++) begin
        if (strobe_i[b]) begin
          mem_d[wrow_i][b*DATA_WIDTH +: DATA_WIDTH] = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    eng_data_d = (32'(eng_row_i) < MAX_DIM) ? mem_q[eng_row_i] : '0;
    rdata_o    = (32'(rrow_i) < MAX_DIM) ? mem_q[rrow_i] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q      <= '{default: '0};
      eng_data_q <= '0;
    end else begin
      mem_q      <= mem_d;
      eng_data_q <= eng_data_d;
    end
  end

  assign eng_data_o = eng_data_q;

endmodule

// File: rtl/matmul_register_bank.sv
// rtl/matmul_register_bank.sv - matmul operand/control/result register bank behind the APB slave
// Purpose: stores operands A and B, CONTROL, FLAGS and the result scratchpad, and
// runs the IDLE/RUN start/done handshake with the matmul engine.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   address_i, strobe_i, wdata_i   bus write/read request from the APB slave
//   rdata_o                        combinational read data
//   start_bit_o, done_i, flags_i   engine handshake
//   eng_row_i, eng_a_o, eng_b_o    registered operand rows for the engine
//   sp_we_i, sp_row_i, sp_data_i   engine scratchpad write port
module matmul_register_bank
  import matmul_register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [MAX_DIM-1:0]    strobe_i,
  input  logic [BUS_WIDTH-1:0]  wdata_i,
  output logic [BUS_WIDTH-1:0]  rdata_o,
  output logic                  start_bit_o,
  input  logic                  done_i,
  input  logic [BUS_WIDTH-1:0]  flags_i,
  input  logic [IDX_W-1:0]      eng_row_i,
  output logic [BUS_WIDTH-1:0]  eng_a_o,
  output logic [BUS_WIDTH-1:0]  eng_b_o,
  input  logic                  sp_we_i,
  input  logic [IDX_W-1:0]      sp_row_i,
  input  logic [BUS_WIDTH-1:0]  sp_data_i
);

  logic [4:0]           region;
  logic [IDX_W-1:0]     row;
  logic                 bus_wr;
  logic                 a_we, b_we;
  logic [BUS_WIDTH-1:0] a_rdata, b_rdata;
  logic                 unused_addr;

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [BUS_WIDTH-1:0] flags_q, flags_d;
  logic [BUS_WIDTH-1:0] sp_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] sp_d [MAX_DIM];
  logic [BUS_WIDTH-1:0] ctrl_rd;

  assign region      = address_i[4:0];
  assign row         = address_i[5 +: IDX_W];
  assign unused_addr = ^address_i[ADDR_WIDTH-1:5+IDX_W];
  assign bus_wr      = |strobe_i;

  // Operands are frozen while the engine runs.
  assign a_we = bus_wr && (region == REG_OPERAND_A) && (state_q == ST_IDLE);
  assign b_we = bus_wr && (region == REG_OPERAND_B) && (state_q == ST_IDLE);

  matmul_row_mem #(
    .DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .MAX_DIM(MAX_DIM), .IDX_W(IDX_W)
  ) u_mem_a (
    .clk_i(clk_i), .rst_i(rst_i), .we_i(a_we), .wrow_i(row), .strobe_i(strobe_i),
    .wdata_i(wdata_i), .rrow_i(row), .rdata_o(a_rdata), .eng_row_i(eng_row_i),
    .eng_data_o(eng_a_o)
  );

  matmul_row_mem #(
    .DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .MAX_DIM(MAX_DIM), .IDX_W(IDX_W)
  ) u_mem_b (
    .clk_i(clk_i), .rst_i(rst_i), .we_i(b_we), .wrow_i(row), .strobe_i(strobe_i),
    .wdata_i(wdata_i), .rrow_i(row), .rdata_o(b_rdata), .eng_row_i(eng_row_i),
    .eng_data_o(eng_b_o)
  );

  // Control FSM and result registers
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    flags_d = flags_q;
    sp_d    = sp_q;

    if (state_q == ST_RUN) begin
      // CONTROL writes are ignored in RUN, so done_i always wins a collision.
      if (done_i) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        flags_d = flags_i;
      end
      // The SP write still lands on the done_i cycle.
      if (sp_we_i && (32'(sp_row_i) < MAX_DIM)) begin
        sp_d[sp_row_i] = sp_data_i;
      end
    end else if ((region == REG_CONTROL) && strobe_i[0] && wdata_i[CTRL_START_BIT]) begin
      state_d = ST_RUN;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      flags_q <= '0;
      sp_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      sp_q    <= sp_d;
    end
  end

  assign start_bit_o = (state_q == ST_RUN);

  // Read mux
  always_comb begin
    ctrl_rd                 = '0;
    ctrl_rd[CTRL_START_BIT] = (state_q == ST_RUN);
    ctrl_rd[CTRL_DONE_BIT]  = done_q;
    case (region)
      REG_CONTROL:   rdata_o = ctrl_rd;
      REG_OPERAND_A: rdata_o = a_rdata;
      REG_OPERAND_B: rdata_o = b_rdata;
      REG_FLAGS:     rdata_o = flags_q;
      REG_SP:        rdata_o = (32'(row) < MAX_DIM) ? sp_q[row] : '0;
      default:       rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_matmul_register_bank.sv
// tb/tb_matmul_register_bank.sv - self-checking bench for matmul_register_bank
module tb_matmul_register_bank;
  import matmul_register_bank_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] address_i;
  logic [1:0]  strobe_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        start_bit_o;
  logic        done_i;
  logic [63:0] flags_i;
  logic [0:0]  eng_row_i;
  logic [63:0] eng_a_o;
  logic [63:0] eng_b_o;
  logic        sp_we_i;
  logic [0:0]  sp_row_i;
  logic [63:0] sp_data_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  matmul_register_bank dut (
    .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .strobe_i(strobe_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .start_bit_o(start_bit_o), .done_i(done_i),
    .flags_i(flags_i), .eng_row_i(eng_row_i), .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
    .sp_we_i(sp_we_i), .sp_row_i(sp_row_i), .sp_data_i(sp_data_i)
  );

  typedef struct {
    logic [4:0]  region;
    logic        row;
    logic [1:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] region, input logic row,
                           input logic [1:0] strobe, input logic [63:0] data);
    @(negedge clk_i);
    address_i = {26'b0, row, region};
    strobe_i  = strobe;
    wdata_i   = data;
    @(negedge clk_i);
    strobe_i  = 2'b00;
  endtask

  task automatic bus_read(input string name, input logic [4:0] region, input logic row,
                          input logic [63:0] exp);
    @(negedge clk_i);
    address_i = {26'b0, row, region};
    strobe_i  = 2'b00;
    #1;
    check(name, rdata_o, exp);
  endtask

  task automatic pulse_done(input logic [63:0] flags);
    @(negedge clk_i);
    done_i  = 1'b1;
    flags_i = flags;
    @(negedge clk_i);
    done_i  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{REG_OPERAND_A, 1'b1, 2'b01, 64'hAAAA_BBBB_1111_2222, 64'h0000_0000_1111_2222};
    vecs[1] = '{REG_OPERAND_A, 1'b1, 2'b10, 64'h3333_4444_5555_6666, 64'h3333_4444_1111_2222};
    vecs[2] = '{REG_OPERAND_A, 1'b0, 2'b11, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{REG_OPERAND_B, 1'b0, 2'b11, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
    vecs[4] = '{REG_OPERAND_B, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[5] = '{REG_FLAGS,     1'b0, 2'b11, 64'h0000_0000_0000_00FF, 64'h0};
    vecs[6] = '{REG_SP,        1'b0, 2'b11, 64'h0000_0000_0000_1234, 64'h0};
    vecs[7] = '{5'h14,         1'b0, 2'b11, 64'h5555_5555_5555_5555, 64'h0};
    vecs[8] = '{5'h02,         1'b0, 2'b11, 64'h5555_5555_5555_5555, 64'h0};
    vecs[9] = '{REG_CONTROL,   1'b0, 2'b10, 64'h0000_0001_0000_0001, 64'h0};

    rst_i = 1'b1; address_i = '0; strobe_i = '0; wdata_i = '0; done_i = 1'b0;
    flags_i = '0; eng_row_i = '0; sp_we_i = 1'b0; sp_row_i = '0; sp_data_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset_start", {63'b0, start_bit_o}, 64'h0);
    check("reset_eng_a", eng_a_o, 64'h0);
    check("reset_eng_b", eng_b_o, 64'h0);
    rst_i = 1'b0;
    bus_read("reset_ctrl", REG_CONTROL, 1'b0, 64'h0);

    for (int i = 0; i < 10; i++) begin
      bus_write(vecs[i].region, vecs[i].row, vecs[i].strobe, vecs[i].wdata);
      bus_read($sformatf("vec%0d", i), vecs[i].region, vecs[i].row, vecs[i].exp);
    end
    check("ctrl_lane1_no_start", {63'b0, start_bit_o}, 64'h0);

    // Engine ports: one-cycle latency from eng_row_i
    @(negedge clk_i); eng_row_i = 1'b1;
    @(negedge clk_i);
    check("eng_a_row1", eng_a_o, 64'h3333_4444_1111_2222);
    check("eng_b_row1", eng_b_o, 64'h0);
    eng_row_i = 1'b0;
    @(negedge clk_i);
    check("eng_a_row0", eng_a_o, 64'h0123_4567_89AB_CDEF);
    check("eng_b_row0", eng_b_o, 64'hFEDC_BA98_7654_3210);

    // Start, then operand/control writes in RUN are dropped
    bus_write(REG_CONTROL, 1'b0, 2'b01, 64'h1);
    check("start_rise", {63'b0, start_bit_o}, 64'h1);
    bus_read("ctrl_run", REG_CONTROL, 1'b0, 64'h1);
    bus_write(REG_OPERAND_B, 1'b1, 2'b11, 64'h5);
    bus_read("b1_run_ignored", REG_OPERAND_B, 1'b1, 64'h0);
    bus_write(REG_OPERAND_B, 1'b0, 2'b11, 64'h5);
    bus_read("b0_run_ignored", REG_OPERAND_B, 1'b0, 64'hFEDC_BA98_7654_3210);
    bus_write(REG_CONTROL, 1'b0, 2'b01, 64'h0);
    check("ctrl_run_write_ignored", {63'b0, start_bit_o}, 64'h1);

    // SP write in RUN
    @(negedge clk_i);
    sp_we_i = 1'b1; sp_row_i = 1'b1; sp_data_i = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk_i);
    sp_we_i = 1'b0;
    bus_read("sp1_run", REG_SP, 1'b1, 64'hDEAD_BEEF_0000_0001);

    // done_i together with an SP write: both take effect
    @(negedge clk_i);
    done_i = 1'b1; flags_i = 64'h3;
    sp_we_i = 1'b1; sp_row_i = 1'b0; sp_data_i = 64'h77;
    @(negedge clk_i);
    done_i = 1'b0; sp_we_i = 1'b0;
    check("start_fall", {63'b0, start_bit_o}, 64'h0);
    bus_read("flags_after_done", REG_FLAGS, 1'b0, 64'h3);
    bus_read("ctrl_done", REG_CONTROL, 1'b0, 64'h2);
    bus_read("sp0_done_cycle", REG_SP, 1'b0, 64'h77);

    // SP write in IDLE is ignored
    @(negedge clk_i);
    sp_we_i = 1'b1; sp_row_i = 1'b1; sp_data_i = 64'h1111;
    @(negedge clk_i);
    sp_we_i = 1'b0;
    bus_read("sp1_idle_ignored", REG_SP, 1'b1, 64'hDEAD_BEEF_0000_0001);

    // Restart clears DONE
    bus_write(REG_CONTROL, 1'b0, 2'b01, 64'h1);
    bus_read("ctrl_restart", REG_CONTROL, 1'b0, 64'h1);

    // done_i in the same cycle as a CONTROL write of 1: done wins
    @(negedge clk_i);
    address_i = {26'b0, 1'b0, REG_CONTROL}; strobe_i = 2'b01; wdata_i = 64'h1;
    done_i = 1'b1; flags_i = 64'h5;
    @(negedge clk_i);
    strobe_i = 2'b00; done_i = 1'b0;
    check("collide_idle", {63'b0, start_bit_o}, 64'h0);
    bus_read("collide_ctrl", REG_CONTROL, 1'b0, 64'h2);
    bus_write(REG_FLAGS, 1'b0, 2'b11, 64'hFF);
    bus_read("flags_ro", REG_FLAGS, 1'b0, 64'h5);

    // Asynchronous reset mid-RUN
    bus_write(REG_CONTROL, 1'b0, 2'b01, 64'h1);
    check("run_before_reset", {63'b0, start_bit_o}, 64'h1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset_start", {63'b0, start_bit_o}, 64'h0);
    check("async_reset_eng_a", eng_a_o, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus_read("post_reset_a0", REG_OPERAND_A, 1'b0, 64'h0);
    bus_read("post_reset_a1", REG_OPERAND_A, 1'b1, 64'h0);
    bus_read("post_reset_b0", REG_OPERAND_B, 1'b0, 64'h0);
    bus_read("post_reset_sp1", REG_SP, 1'b1, 64'h0);
    bus_read("post_reset_flags", REG_FLAGS, 1'b0, 64'h0);
    bus_read("post_reset_ctrl", REG_CONTROL, 1'b0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
